// File: rtl/axi_dw_downsize_w_sequencer_pkg.sv
// Local definitions for the downsizer W-channel sequencer: FSM state
// encoding and the size clamp helper shared by the address stepper.
package axi_dw_downsize_w_sequencer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } seq_state_e;

    // Narrow beats never carry more than one MI word: clamp size to lim.
    function automatic axi_pkg::size_t clamp_size(input axi_pkg::size_t size,
                                                  input axi_pkg::size_t lim);
        axi_pkg::size_t res;
        if (size > lim) begin
            res = lim;
        end else begin
            res = size;
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_pkg.sv
// Shared AXI type definitions.
// Provides the AxSIZE/AxBURST encodings and the command record that the
// data width converter hands from its AW path to its W-channel sequencer.
package axi_pkg;

    typedef logic [2:0] size_t;
    typedef logic [1:0] burst_t;

    localparam burst_t BURST_FIXED = 2'b00;
    localparam burst_t BURST_INCR  = 2'b01;
    localparam burst_t BURST_WRAP  = 2'b10;

    // Wide enough for the byte offset of any supported SI word.
    localparam int unsigned DW_ADDR_W = 8;

    // Write command for the downsizer W sequencer.
    typedef struct packed {
        logic [DW_ADDR_W-1:0] addr;
        logic [7:0]           len;
        size_t                size;
        burst_t               burst;
    } dw_w_cmd_t;

endpackage

// File: rtl/axi_dw_downsize_w_sequencer_if.sv
// Bus bundle of the downsizer W sequencer.
// slave  : sequencer side (command in, wide W in, narrow W out, status out)
// master : environment side (drives command, wide W and narrow ready)
interface axi_dw_downsize_w_sequencer_if #(
    parameter int unsigned SI_DATA_WIDTH = 256,
    parameter int unsigned MI_DATA_WIDTH = 32
);
    localparam int unsigned SI_SZ = $clog2(SI_DATA_WIDTH / 8);
    localparam int unsigned MI_SZ = $clog2(MI_DATA_WIDTH / 8);
    localparam int unsigned LW    = SI_SZ - MI_SZ;

    logic                   cmd_valid_i;
    logic                   cmd_ready_o;
    logic [SI_SZ-1:0]       cmd_addr_i;
    logic [7:0]             cmd_len_i;
    axi_pkg::size_t         cmd_size_i;
    axi_pkg::burst_t        cmd_burst_i;
    logic                   slv_w_valid_i;
    logic                   slv_w_last_i;
    logic                   slv_w_ready_o;
    logic                   mst_w_valid_o;
    logic                   mst_w_ready_i;
    logic                   mst_w_last_o;
    logic [LW-1:0]          lane_sel_o;
    logic                   busy_o;
    logic                   err_o;

    modport slave (
        input  cmd_valid_i, cmd_addr_i, cmd_len_i, cmd_size_i, cmd_burst_i,
        input  slv_w_valid_i, slv_w_last_i, mst_w_ready_i,
        output cmd_ready_o, slv_w_ready_o, mst_w_valid_o, mst_w_last_o,
        output lane_sel_o, busy_o, err_o
    );

    modport master (
        output cmd_valid_i, cmd_addr_i, cmd_len_i, cmd_size_i, cmd_burst_i,
        output slv_w_valid_i, slv_w_last_i, mst_w_ready_i,
        input  cmd_ready_o, slv_w_ready_o, mst_w_valid_o, mst_w_last_o,
        input  lane_sel_o, busy_o, err_o
    );

endinterface

// File: rtl/axi_dw_addr_step.sv
// Narrow-beat address stepper (combinational).
// addr      : current byte offset within the SI word
// size      : AxSIZE of the burst
// next_addr : offset of the following narrow beat (wraps modulo SI word)
// end_wide  : the current narrow beat is the last one of its 2^size unit
module axi_dw_addr_step
    import axi_dw_downsize_w_sequencer_pkg::*;
#(
    parameter int unsigned SI_SZ = 5,
    parameter int unsigned MI_SZ = 2
) (
    input  logic [SI_SZ-1:0] addr,
    input  axi_pkg::size_t   size,
    output logic [SI_SZ-1:0] next_addr,
    output logic             end_wide
);

    axi_pkg::size_t   eff_s;
    logic [SI_SZ-1:0] step_s;
    logic [SI_SZ-1:0] size_mask_s;

    // Align down to the narrow transfer size, advance one transfer, test unit end.
    always_comb begin
        eff_s       = clamp_size(size, 3'(MI_SZ));
        step_s      = SI_SZ'(1) << eff_s;
        next_addr   = (addr & ~(step_s - SI_SZ'(1))) + step_s;
        // size == SI_SZ shifts every bit out, giving an all-ones mask.
        size_mask_s = ~({SI_SZ{1'b1}} << size);
        end_wide    = ((next_addr & size_mask_s) == '0);
    end

endmodule

// File: rtl/axi_dw_downsize_w_sequencer.sv
// W-channel sequencer of the SI->MI downsizing data width converter.
// clk_i / rst_i : clock, synchronous active-high reset
// bus (slave)   : command from the AW path, wide W handshake (slv_w_*),
//                 narrow W handshake (mst_w_*), MI lane select for the
//                 external data mux, busy flag and W-last error pulse.
// A command is consumed per burst; each wide beat is popped once all of its
// bytes have been issued as narrow beats.

// Command legality checks, kept apart from the sequencing logic.
module axi_dw_downsize_w_sequencer_chk #(
    parameter int unsigned SI_SZ = 5
) (
    input logic                           clk_i,
    input logic                           rst_i,
    input logic                           cmd_hs,
    input axi_pkg::size_t                 cmd_size,
    input axi_pkg::burst_t                cmd_burst,
    input logic [axi_pkg::DW_ADDR_W-1:0]  start_addr
);

    a_cmd_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        cmd_hs |-> ((cmd_size <= 3'(SI_SZ)) && (cmd_burst != axi_pkg::BURST_WRAP)));

    a_start_in_word: assert property (@(posedge clk_i) disable iff (rst_i)
        ((start_addr >> SI_SZ) == '0));

endmodule

module axi_dw_downsize_w_sequencer
    import axi_pkg::*;
    import axi_dw_downsize_w_sequencer_pkg::*;
#(
    parameter int unsigned SI_DATA_WIDTH = 256,
    parameter int unsigned MI_DATA_WIDTH = 32
) (
    input logic                            clk_i,
    input logic                            rst_i,
    axi_dw_downsize_w_sequencer_if.slave   bus
);

    localparam int unsigned SI_SZ = $clog2(SI_DATA_WIDTH / 8);
    localparam int unsigned MI_SZ = $clog2(MI_DATA_WIDTH / 8);
    localparam int unsigned LW    = SI_SZ - MI_SZ;

    seq_state_e       state_r;
    seq_state_e       state_next_s;
    logic [SI_SZ-1:0] addr_r;
    dw_w_cmd_t        cmd_r;
    dw_w_cmd_t        cmd_s;
    logic [7:0]       cnt_r;
    logic             err_r;

    logic [SI_SZ-1:0] step_addr_s;
    logic             end_wide_s;
    logic             cnt_end_s;
    logic             cmd_ready_s;
    logic             busy_s;
    logic             mst_valid_s;
    logic             slv_ready_s;
    logic             mst_last_s;
    logic             cmd_hs_s;
    logic             mst_hs_s;

    axi_dw_addr_step #(
        .SI_SZ (SI_SZ),
        .MI_SZ (MI_SZ)
    ) u_step (
        .addr      (addr_r),
        .size      (cmd_r.size),
        .next_addr (step_addr_s),
        .end_wide  (end_wide_s)
    );

    // Pack the incoming command; start offset is zero-extended into the record.
    always_comb begin
        cmd_s       = '0;
        cmd_s.addr  = DW_ADDR_W'(bus.cmd_addr_i);
        cmd_s.len   = bus.cmd_len_i;
        cmd_s.size  = bus.cmd_size_i;
        cmd_s.burst = bus.cmd_burst_i;
    end

    assign cnt_end_s = (cnt_r == cmd_r.len);
    assign cmd_hs_s  = cmd_ready_s & bus.cmd_valid_i;
    assign mst_hs_s  = mst_valid_s & bus.mst_w_ready_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_next_s = state_r;
        cmd_ready_s  = 1'b0;
        busy_s       = 1'b0;
        mst_valid_s  = 1'b0;
        slv_ready_s  = 1'b0;
        mst_last_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cmd_ready_s = 1'b1;
                if (bus.cmd_valid_i) begin
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                busy_s      = 1'b1;
                mst_valid_s = bus.slv_w_valid_i;
                slv_ready_s = bus.mst_w_ready_i & bus.slv_w_valid_i & end_wide_s;
                mst_last_s  = end_wide_s & cnt_end_s;
                if (bus.slv_w_valid_i && bus.mst_w_ready_i && end_wide_s && cnt_end_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Command capture, narrow address walk, wide beat count and error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_r <= '0;
            cmd_r  <= '0;
            cnt_r  <= 8'd0;
            err_r  <= 1'b0;
        end else begin
            if (cmd_hs_s) begin
                addr_r <= bus.cmd_addr_i;
                cmd_r  <= cmd_s;
                cnt_r  <= 8'd0;
            end else if (mst_hs_s) begin
                if (!end_wide_s) begin
                    addr_r <= step_addr_s;
                end else begin
                    // FIXED replays the same byte lanes for every wide beat.
                    if (cmd_r.burst == BURST_FIXED) begin
                        addr_r <= cmd_r.addr[SI_SZ-1:0];
                    end else begin
                        addr_r <= step_addr_s;
                    end
                    cnt_r <= cnt_r + 8'd1;
                end
            end
            // Sequencing trusts cnt_r; slv_w_last_i is only cross-checked.
            err_r <= slv_ready_s & (bus.slv_w_last_i != cnt_end_s);
        end
    end

    // Outputs are forced low during the reset cycle.
    assign bus.cmd_ready_o   = cmd_ready_s & ~rst_i;
    assign bus.busy_o        = busy_s      & ~rst_i;
    assign bus.mst_w_valid_o = mst_valid_s & ~rst_i;
    assign bus.slv_w_ready_o = slv_ready_s & ~rst_i;
    assign bus.mst_w_last_o  = mst_last_s  & ~rst_i;
    assign bus.err_o         = err_r       & ~rst_i;
    assign bus.lane_sel_o    = rst_i ? {LW{1'b0}} : addr_r[SI_SZ-1:MI_SZ];

    axi_dw_downsize_w_sequencer_chk #(
        .SI_SZ (SI_SZ)
    ) u_chk (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cmd_hs     (cmd_hs_s),
        .cmd_size   (bus.cmd_size_i),
        .cmd_burst  (bus.cmd_burst_i),
        .start_addr (cmd_r.addr)
    );

endmodule

// File: tb/tb_axi_dw_downsize_w_sequencer.sv
module tb_axi_dw_downsize_w_sequencer;
    import axi_pkg::*;

    localparam int SI = 256;
    localparam int MI = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_dw_downsize_w_sequencer_if #(.SI_DATA_WIDTH(SI), .MI_DATA_WIDTH(MI)) bus ();

    axi_dw_downsize_w_sequencer #(.SI_DATA_WIDTH(SI), .MI_DATA_WIDTH(MI)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int lane;
        bit pop;
        bit last;
        int wide;
    } beat_t;

    typedef struct {
        int          addr;
        int          len;
        int          size;
        logic [1:0]  burst;
        int          nbeats;
        logic [63:0] lanes;   // lane of narrow beat i in nibble i
        logic [15:0] pops;    // bit i set: wide pop on narrow beat i
        int          err_wide;
    } vec_t;

    beat_t exp_q[$];
    vec_t  tbl[5];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk the bytes of each wide beat in narrow transfers.
    function automatic void build_model(input int addr, input int len, input int size,
                                        input logic [1:0] burst);
        int nb, nn, bs, be, b, bn;
        exp_q.delete();
        nb = 1 << size;
        nn = 1 << ((size < 2) ? size : 2);
        for (int k = 0; k <= len; k++) begin
            if (burst == BURST_FIXED || k == 0) bs = addr;
            else bs = (addr / nb) * nb + k * nb;
            be = (bs / nb) * nb + nb;
            b = bs;
            while (b < be) begin
                beat_t e;
                bn = (b / nn) * nn + nn;
                e.lane = (b % 32) / 4;
                e.pop  = (bn >= be);
                e.last = e.pop && (k == len);
                e.wide = k;
                exp_q.push_back(e);
                b = bn;
            end
        end
    endfunction

    function automatic void table_to_q(input vec_t v);
        int w;
        w = 0;
        exp_q.delete();
        for (int i = 0; i < v.nbeats; i++) begin
            beat_t e;
            e.lane = int'(v.lanes[4*i +: 4]);
            e.pop  = v.pops[i];
            e.last = (i == v.nbeats - 1);
            e.wide = w;
            exp_q.push_back(e);
            if (v.pops[i]) w++;
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready_o), 32'd0);
        check({tag, "_busy"},      32'(bus.busy_o), 32'd0);
        check({tag, "_mst_valid"}, 32'(bus.mst_w_valid_o), 32'd0);
        check({tag, "_slv_ready"}, 32'(bus.slv_w_ready_o), 32'd0);
        check({tag, "_last"},      32'(bus.mst_w_last_o), 32'd0);
        check({tag, "_lane"},      32'(bus.lane_sel_o), 32'd0);
        check({tag, "_err"},       32'(bus.err_o), 32'd0);
    endtask

    // Issue a command and play out the expected beats held in exp_q.
    task automatic run_burst(input int addr, input int len, input int size,
                             input logic [1:0] burst, input bit rnd, input int err_wide);
        bit v, r, err_exp, prev_stall;
        int prev_lane, cyc;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_addr_i  = 5'(addr);
        bus.cmd_len_i   = 8'(len);
        bus.cmd_size_i  = 3'(size);
        bus.cmd_burst_i = burst;
        bus.slv_w_valid_i = 1'b0;
        #1;
        check("idle_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        check("idle_busy", 32'(bus.busy_o), 32'd0);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        err_exp = 1'b0;
        prev_stall = 1'b0;
        prev_lane = 0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 600) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.slv_w_valid_i = v;
            bus.mst_w_ready_i = r;
            bus.slv_w_last_i  = (exp_q[0].wide == len) ^ (exp_q[0].wide == err_wide);
            #1;
            check("err", 32'(bus.err_o), 32'(err_exp));
            check("busy", 32'(bus.busy_o), 32'd1);
            check("mst_valid", 32'(bus.mst_w_valid_o), 32'(v));
            if (v) begin
                check("lane", 32'(bus.lane_sel_o), 32'(exp_q[0].lane));
                check("slv_ready", 32'(bus.slv_w_ready_o), 32'(r && exp_q[0].pop));
                check("mst_last", 32'(bus.mst_w_last_o), 32'(exp_q[0].last));
                if (prev_stall) check("lane_stable", 32'(bus.lane_sel_o), 32'(prev_lane));
            end
            err_exp = v && r && exp_q[0].pop && (bus.slv_w_last_i != (exp_q[0].wide == len));
            prev_stall = v && !r;
            prev_lane = int'(bus.lane_sel_o);
            if (v && r) void'(exp_q.pop_front());
        end
        check("beats_left", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        bus.slv_w_valid_i = 1'b0;
        bus.mst_w_ready_i = 1'b1;
        #1;
        check("done_busy", 32'(bus.busy_o), 32'd0);
        check("done_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        check("done_err", 32'(bus.err_o), 32'(err_exp));
        if (exp_q.size() > 0) begin
            exp_q.delete();
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{addr: 'h00, len: 0, size: 5, burst: BURST_INCR,  nbeats: 8,
                   lanes: 64'h0000_0000_7654_3210, pops: 16'h0080, err_wide: -1};
        tbl[1] = '{addr: 'h0C, len: 1, size: 5, burst: BURST_INCR,  nbeats: 13,
                   lanes: 64'h0007_6543_2107_6543, pops: 16'h1010, err_wide: -1};
        tbl[2] = '{addr: 'h02, len: 3, size: 1, burst: BURST_INCR,  nbeats: 4,
                   lanes: 64'h0000_0000_0000_2110, pops: 16'h000F, err_wide: -1};
        tbl[3] = '{addr: 'h10, len: 2, size: 3, burst: BURST_FIXED, nbeats: 6,
                   lanes: 64'h0000_0000_0054_5454, pops: 16'h002A, err_wide: -1};
        tbl[4] = '{addr: 'h00, len: 1, size: 5, burst: BURST_INCR,  nbeats: 16,
                   lanes: 64'h7654_3210_7654_3210, pops: 16'h8080, err_wide: 0};

        bus.cmd_valid_i = 1'b0;
        bus.cmd_addr_i = '0;
        bus.cmd_len_i = '0;
        bus.cmd_size_i = '0;
        bus.cmd_burst_i = BURST_INCR;
        bus.slv_w_valid_i = 1'b0;
        bus.slv_w_last_i = 1'b0;
        bus.mst_w_ready_i = 1'b1;

        // Reset: every output low, then IDLE.
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        check("post_reset_busy", 32'(bus.busy_o), 32'd0);

        // Directed table.
        for (int i = 0; i < 5; i++) begin
            table_to_q(tbl[i]);
            run_burst(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, 1'b0, tbl[i].err_wide);
        end

        // Unaligned INCR burst under random backpressure and valid gaps.
        for (int i = 0; i < 4; i++) begin
            build_model('h0C, 1, 5, BURST_INCR);
            run_burst('h0C, 1, 5, BURST_INCR, 1'b1, -1);
        end

        // Random legal commands against the reference walk.
        for (int i = 0; i < 30; i++) begin
            int a, l, s;
            logic [1:0] b;
            a = int'($urandom_range(0, 31));
            l = int'($urandom_range(0, 3));
            s = int'($urandom_range(0, 5));
            b = ($urandom_range(0, 1) == 0) ? BURST_FIXED : BURST_INCR;
            build_model(a, l, s, b);
            run_burst(a, l, s, b, 1'b1, -1);
        end

        // Reset in the middle of a burst.
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_addr_i = 5'h0C;
        bus.cmd_len_i = 8'd1;
        bus.cmd_size_i = 3'd5;
        bus.cmd_burst_i = BURST_INCR;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        bus.slv_w_valid_i = 1'b1;
        bus.mst_w_ready_i = 1'b1;
        bus.slv_w_last_i = 1'b0;
        #1;
        check("abort_lane0", 32'(bus.lane_sel_o), 32'd3);
        @(negedge clk);
        #1;
        check("abort_lane1", 32'(bus.lane_sel_o), 32'd4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        check("abort_busy", 32'(bus.busy_o), 32'd0);
        check("abort_mst_valid", 32'(bus.mst_w_valid_o), 32'd0);
        check("abort_slv_ready", 32'(bus.slv_w_ready_o), 32'd0);
        bus.slv_w_valid_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
